// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code encodings, NZCV bit positions and hazard FSM states.
package arm_cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PEND  = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   // AL and NV never look at the flags, so they can issue past pending writers.
   function automatic logic cond_is_flag_dep(input logic [3:0] cond);
      return !((cond == COND_AL) || (cond == COND_NV));
   endfunction

endpackage

// File: rtl/flag_hazard_ctrl_cond_eval.sv
// Combinational ARM condition evaluator: cond + NZCV -> pass.
module cond_eval
   import arm_cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Decode the condition field against the selected flag source.
   always_comb begin
      pass = 1'b1;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Decode-stage flag hazard control: tracks outstanding flag writers, forwards
// execute flags when exactly one is in flight, and stalls dependent issue.
module flag_hazard_ctrl
   import arm_cond_pkg::*;
#(
   parameter int MAX_PEND = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [3:0] id_cond,
   input  logic       id_set_flags,
   input  logic       ex_flag_we,
   input  logic [3:0] ex_flags,
   input  logic       flush,
   output logic       id_ready,
   output logic       ex_valid,
   output logic       ex_exec,
   output logic [3:0] flags_q,
   output logic [1:0] pend_cnt,
   output logic       err
);

   localparam logic [1:0] MAX_PEND_C = 2'(MAX_PEND);

   state_e     state_q, state_d;
   logic [1:0] pend_cnt_q, pend_cnt_d;
   logic [3:0] flags_d;
   logic       ex_valid_q, ex_valid_d;
   logic       ex_exec_q, ex_exec_d;
   logic       err_q, err_d;

   logic       flag_dep, src_ok, cond_pass;
   logic       stall_dep, stall_full, stall;
   logic       issue, cnt_inc, cnt_dec;
   logic [3:0] src_flags;

   // Pick the flags a dependent instruction should see: architectural when
   // nothing is pending, the execute result when the only writer commits now.
   always_comb begin
      flag_dep  = cond_is_flag_dep(id_cond);
      src_ok    = (pend_cnt_q == 2'd0) || ((pend_cnt_q == 2'd1) && ex_flag_we);
      src_flags = (pend_cnt_q == 2'd0) ? flags_q : ex_flags;
   end

   cond_eval u_cond_eval (
      .cond  (id_cond),
      .flags (src_flags),
      .pass  (cond_pass)
   );

   // Issue decision; flush and reset both block acceptance outright.
   always_comb begin
      stall_dep  = id_valid && flag_dep && !src_ok;
      stall_full = id_valid && id_set_flags && (pend_cnt_q == MAX_PEND_C) && !ex_flag_we;
      stall      = stall_dep || stall_full;
      issue      = id_valid && !flush && !stall && !rst;
      id_ready   = issue;
      // A setter whose condition fails writes no flags, so it is not counted.
      cnt_inc    = issue && id_set_flags && cond_pass;
      cnt_dec    = ex_flag_we && (pend_cnt_q != 2'd0);
   end

   // Next values for the counter, flags, execute handoff and error flag.
   always_comb begin
      pend_cnt_d = pend_cnt_q + {1'b0, cnt_inc} - {1'b0, cnt_dec};
      if (flush) pend_cnt_d = 2'd0;
      flags_d    = ex_flag_we ? ex_flags : flags_q;
      ex_valid_d = issue;
      ex_exec_d  = issue && cond_pass;
      err_d      = err_q || (ex_flag_we && (pend_cnt_q == 2'd0) && !flush);
   end

   // FSM next state; RUN/PEND follow the counter, STALL mirrors a held issue.
   always_comb begin
      state_e settle;
      settle  = (pend_cnt_d == 2'd0) ? ST_RUN : ST_PEND;
      state_d = state_q;
      case (state_q)
         ST_RUN:   state_d = stall ? ST_STALL : settle;
         ST_PEND:  state_d = stall ? ST_STALL : settle;
         ST_STALL: state_d = stall ? ST_STALL : settle;
         default:  state_d = ST_RUN;
      endcase
      if (flush) state_d = ST_RUN;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pend_cnt_q <= 2'd0;
         flags_q    <= 4'd0;
         ex_valid_q <= 1'b0;
         ex_exec_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_cnt_q <= pend_cnt_d;
         flags_q    <= flags_d;
         ex_valid_q <= ex_valid_d;
         ex_exec_q  <= ex_exec_d;
         err_q      <= err_d;
      end
   end

   assign pend_cnt = pend_cnt_q;
   assign ex_valid = ex_valid_q;
   assign ex_exec  = ex_exec_q;
   assign err      = err_q;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Bench for flag_hazard_ctrl: directed scenarios then random traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_flag_hazard_ctrl;

   localparam int MAXP = 3;

   logic       clk, rst;
   logic       id_valid, id_set_flags, ex_flag_we, flush;
   logic [3:0] id_cond, ex_flags;
   logic       id_ready, ex_valid, ex_exec, err;
   logic [3:0] flags_q;
   logic [1:0] pend_cnt;

   flag_hazard_ctrl #(.MAX_PEND(MAXP)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond),
      .id_set_flags(id_set_flags), .ex_flag_we(ex_flag_we), .ex_flags(ex_flags),
      .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid), .ex_exec(ex_exec),
      .flags_q(flags_q), .pend_cnt(pend_cnt), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         tests = 0;
   int         fails = 0;
   int         m_pend;
   logic [3:0] m_flags;
   bit         m_err;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // ARM conditions come in pairs: odd encodings invert the even predicate.
   function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cc, v, r;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cc;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cc && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c < 4'd14 && c[0]) r = !r;
      return r;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_flags = 4'd0; m_err = 1'b0;
   endtask

   // One clock: drive, check id_ready, advance model, check registered outputs.
   task automatic step(input bit v, input logic [3:0] c, input bit s,
                       input bit we, input logic [3:0] ef, input bit f);
      bit dep, srcok, pass, rdy, e_vld, e_exe;
      logic [3:0] src;
      id_valid = v; id_cond = c; id_set_flags = s;
      ex_flag_we = we; ex_flags = ef; flush = f;
      #1;
      dep   = (c < 4'd14);
      srcok = (m_pend == 0) || (m_pend == 1 && we);
      src   = (m_pend == 0) ? m_flags : ef;
      pass  = dep ? ref_pass(c, src) : 1'b1;
      rdy   = v && !f && !(dep && !srcok) && !(s && m_pend == MAXP && !we);
      chk("id_ready", {3'b0, id_ready}, {3'b0, rdy});
      e_vld = rdy;
      e_exe = rdy && pass;
      if (we && m_pend == 0 && !f) m_err = 1'b1;
      if (f) m_pend = 0;
      else m_pend = m_pend + ((rdy && s && pass) ? 1 : 0) - ((we && m_pend > 0) ? 1 : 0);
      if (we) m_flags = ef;
      @(posedge clk);
      #1;
      chk("ex_valid", {3'b0, ex_valid}, {3'b0, e_vld});
      chk("ex_exec",  {3'b0, ex_exec},  {3'b0, e_exe});
      chk("flags_q",  flags_q, m_flags);
      chk("pend_cnt", {2'b0, pend_cnt}, 4'(m_pend));
      chk("err",      {3'b0, err}, {3'b0, m_err});
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {3'b0, id_ready}, 4'd0);
      chk({tag, "_exv"},   {3'b0, ex_valid}, 4'd0);
      chk({tag, "_exe"},   {3'b0, ex_exec},  4'd0);
      chk({tag, "_flags"}, flags_q, 4'd0);
      chk({tag, "_pend"},  {2'b0, pend_cnt}, 4'd0);
      chk({tag, "_err"},   {3'b0, err}, 4'd0);
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 1'b1; id_cond = 4'h0; id_set_flags = 1'b0;
      ex_flag_we = 1'b0; ex_flags = 4'h0; flush = 1'b0;
      model_reset();
      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      rst = 1'b0;

      // EQ with flags 0000 issues but fails its condition.
      step(1, 4'h0, 0, 0, 4'h0, 0);
      chk("eq_exec", {3'b0, ex_exec}, 4'd0);

      // ADDS then BEQ: stall until the forwarded Z arrives.
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'h0, 0, 0, 4'h0, 0);
      chk("beq_stall_pend", {2'b0, pend_cnt}, 4'd1);
      step(1, 4'h0, 0, 0, 4'h0, 0);
      step(1, 4'h0, 0, 1, 4'b0100, 0);
      chk("beq_fwd_exec", {3'b0, ex_exec}, 4'd1);
      chk("beq_fwd_flags", flags_q, 4'b0100);

      // Fill the counter, stall a fourth setter, then issue it on a commit.
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      chk("full_pend", {2'b0, pend_cnt}, 4'd3);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      chk("full_stall_exv", {3'b0, ex_valid}, 4'd0);
      step(1, 4'hE, 1, 1, 4'b0100, 0);
      chk("full_swap_pend", {2'b0, pend_cnt}, 4'd3);

      // Flush with a commit, then a failed NE setter must not count.
      step(0, 4'h0, 0, 1, 4'b0100, 1);
      step(1, 4'h1, 1, 0, 4'h0, 0);
      chk("ne_fail_pend", {2'b0, pend_cnt}, 4'd0);

      // Two pending setters killed by flush with a concurrent flag write.
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'hE, 1, 1, 4'b1001, 1);
      chk("flush_pend", {2'b0, pend_cnt}, 4'd0);
      chk("flush_flags", flags_q, 4'b1001);
      chk("flush_exv", {3'b0, ex_valid}, 4'd0);

      // Spurious commit with nothing pending latches err.
      step(0, 4'h0, 0, 1, 4'b0011, 0);
      chk("err_set", {3'b0, err}, 4'd1);
      step(0, 4'h0, 0, 0, 4'h0, 0);
      chk("err_sticky", {3'b0, err}, 4'd1);

      // Random traffic with commits biased toward times a writer is pending.
      for (int i = 0; i < 400; i++) begin
         bit v, s, we, f;
         logic [3:0] c, ef;
         v  = ($urandom_range(0, 3) != 0);
         c  = 4'($urandom_range(0, 15));
         s  = 1'($urandom_range(0, 1));
         we = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         f  = ($urandom_range(0, 19) == 0);
         ef = 4'($urandom_range(0, 15));
         step(v, c, s, we, ef, f);
      end

      // Reset in the middle of outstanding setters.
      step(0, 4'h0, 0, 0, 4'h0, 1);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      step(1, 4'hE, 1, 0, 4'h0, 0);
      id_valid = 1'b1; id_cond = 4'h0; id_set_flags = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(1, 4'h0, 0, 0, 4'h0, 0);
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              (m_pend > 0) && ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/flag_hazard_ctrl.md
FLAG_HAZARD_CTRL -- requirements
Module: flag_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, meaning the maximum number of outstanding flag-setting instructions tracked (2-bit counter).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds an instruction.
- id_cond  in  4  ARM condition field.
- id_set_flags  in  1  S-bit of decode instruction.
- ex_flag_we  in  1  execute stage commits new flags this cycle.
- ex_flags  in  4  {N,Z,C,V} from execute; bit3=N, bit2=Z, bit1=C, bit0=V.
- flush  in  1  branch or exception kill of all younger instructions.
- id_ready  out  1  decode instruction accepted this cycle (combinational).
- ex_valid  out  1  registered: an instruction entered execute.
- ex_exec  out  1  registered: that instruction's condition passed.
- flags_q  out  4  architectural NZCV register.
- pend_cnt  out  2  outstanding flag writers.
- err  out  1  sticky protocol error.

Function
REQ-003 SHALL evaluate conditions 0000-1101 as EQ,NE,CS,CC,MI,PL,VS,VC,HI(C&~Z),LS(~C|Z),GE(N==V),LT(N!=V),GT(~Z&N==V),LE(Z|N!=V); 1110 and 1111 SHALL always pass.
REQ-004 SHALL classify id_cond in {1110,1111} as flag-independent; all others flag-dependent.
REQ-005 SHALL select the evaluation flag source: flags_q when pend_cnt==0; ex_flags when pend_cnt==1 and ex_flag_we==1 (forwarding); otherwise no valid source.
REQ-006 SHALL stall (id_ready=0) when id_valid and the instruction is flag-dependent with no valid source.
REQ-007 SHALL stall when id_valid, id_set_flags and pend_cnt==MAX_PEND and ex_flag_we==0.
REQ-008 SHALL drive id_ready=0 whenever flush==1; flush outranks issue.
REQ-009 SHALL, one cycle after id_ready, set ex_valid=1 and ex_exec=condition result; otherwise ex_valid=0, ex_exec=0.
REQ-010 SHALL increment pend_cnt on issue only when id_set_flags=1 and condition passed; a failed-condition setter SHALL NOT count.
REQ-011 SHALL decrement pend_cnt on ex_flag_we; simultaneous increment and decrement SHALL leave pend_cnt unchanged.
REQ-012 SHALL load flags_q from ex_flags on the cycle after ex_flag_we, including during flush.
REQ-013 SHALL, on flush, set pend_cnt to 0 on the next edge regardless of concurrent issue or ex_flag_we.
REQ-014 SHALL set err=1 when ex_flag_we arrives with pend_cnt==0 and no flush; flags still load; pend_cnt stays 0 (no underflow).
REQ-015 SHALL maintain FSM state RUN (pend_cnt==0), PEND (pend_cnt>0, not stalled), and STALL (id_valid and stalled).
REQ-016 SHALL follow these FSM transitions:
- RUN->PEND on a counted issue.
- PEND->RUN when pend_cnt reaches 0.
- PEND->STALL when REQ-006 or REQ-007 holds.
- STALL->PEND/RUN when the stall clears.
- Any state->RUN on flush.

Reset
REQ-017 SHALL, while rst=1, asynchronously force flags_q=0000, pend_cnt=0, ex_valid=0, ex_exec=0, err=0, state=RUN; id_ready SHALL be 0 during reset.
REQ-018 SHALL discard any in-flight setter count on reset mid-operation; the first edge after release behaves as RUN.

Structure
REQ-019 SHALL place the condition-code constants (EQ..NV), the flag bit indices (N=3, Z=2, C=1, V=0) and the FSM state encoding in shared package arm_cond_pkg.
REQ-020 SHALL implement REQ-003 in one combinational sub-module, cond_eval (cond, flags -> pass), instantiated once.
REQ-021 SHALL keep the remaining logic synchronous to clk, without latches.

Verification
REQ-022 SHALL cover:
- Reset then id_cond=0000, flags 0000, id_valid=1 -> id_ready=1; next cycle ex_valid=1, ex_exec=0.
- ADDS (id_set_flags=1, cond 1110) issued, then BEQ (0000) next cycle -> id_ready=0, pend_cnt=1, until ex_flag_we with ex_flags=0100 -> same cycle id_ready=1; next cycle ex_exec=1, flags_q=0100.
- Three back-to-back setters with no ex_flag_we -> pend_cnt=3; 4th setter stalls; ex_flag_we same cycle -> 4th issues, pend_cnt stays 3.
- Setter with cond 0001 while Z=1 -> ex_exec=0, pend_cnt unchanged.
- pend_cnt=2, flush with concurrent ex_flag_we, ex_flags=1001 -> next cycle pend_cnt=0, flags_q=1001, ex_valid=0.
- ex_flag_we with pend_cnt=0 -> err=1 and stays 1 until rst.
